// File: rtl/mm_job_arbiter.sv
// Two-requester round-robin front end for a shared 2x2 matrix multiplier (one DW x DW product per cycle).
// Build option: define MM_SAT_EN for unsigned saturation of result elements; default wraps modulo 2^DW.
module mm_job_arbiter #(
  parameter int unsigned DW      = 8,
  parameter int unsigned RR_INIT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      req,
  input  logic [4*DW-1:0] a0,
  input  logic [4*DW-1:0] b0,
  input  logic [4*DW-1:0] a1,
  input  logic [4*DW-1:0] b1,
  output logic [1:0]      gnt,
  output logic            busy,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            res_id,
  output logic [4*DW-1:0] res_c
);

  localparam int unsigned MW = 4 * DW;
  localparam int unsigned PW = 2 * DW;
  localparam int unsigned AW = 2 * DW + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [2:0]      step_q, step_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            res_valid_q, res_valid_d;
  logic            res_id_q, res_id_d;
  logic [MW-1:0]   a_q, a_d;
  logic [MW-1:0]   b_q, b_d;
  logic [AW-1:0]   acc_q [4];
  logic [AW-1:0]   acc_d [4];

  logic [DW-1:0]   a_arr [4];
  logic [DW-1:0]   b_arr [4];
  logic [1:0]      a_idx, b_idx, c_idx;
  logic [PW-1:0]   prod;
  logic            win;

  // Unpack captured operands into element arrays for the step-indexed mux.
  for (genvar g = 0; g < 4; g++) begin : g_el
    assign a_arr[g] = a_q[DW*g +: DW];
    assign b_arr[g] = b_q[DW*g +: DW];
  end

  // Step k: c = k>>1 selects the accumulator, t = k&1 the inner-product term.
  assign c_idx = step_q[2:1];
  assign a_idx = {step_q[2], step_q[0]};
  assign b_idx = {step_q[0], step_q[1]};
  assign prod  = PW'(a_arr[a_idx]) * PW'(b_arr[b_idx]);

  assign win = (req == 2'b10) ? 1'b1 :
               (req == 2'b01) ? 1'b0 : rr_ptr_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_d       = 2'b00;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    res_id_d    = res_id_q;
    a_d         = a_q;
    b_d         = b_q;
    for (int i = 0; i < 4; i++) acc_d[i] = acc_q[i];

    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          state_d  = ST_MAC;
          gnt_d    = win ? 2'b10 : 2'b01;
          res_id_d = win;
          a_d      = win ? a1 : a0;
          b_d      = win ? b1 : b0;
          step_d   = 3'd0;
          busy_d   = 1'b1;
          for (int i = 0; i < 4; i++) acc_d[i] = '0;
        end
      end
      ST_MAC: begin
        acc_d[c_idx] = acc_q[c_idx] + AW'(prod);
        step_d       = step_q + 3'd1;
        if (step_q == 3'd7) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        // Hand priority to the other requester once the result is consumed.
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          busy_d      = 1'b0;
          rr_ptr_d    = ~res_id_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      step_q      <= 3'd0;
      rr_ptr_q    <= 1'(RR_INIT);
      gnt_q       <= 2'b00;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      a_q         <= a_d;
      b_q         <= b_d;
      for (int i = 0; i < 4; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Reduce each accumulator to DW bits; held constant through DONE.
  for (genvar g = 0; g < 4; g++) begin : g_res
`ifdef MM_SAT_EN
    assign res_c[DW*g +: DW] = (|acc_q[g][AW-1:DW]) ? {DW{1'b1}} : acc_q[g][DW-1:0];
`else
    assign res_c[DW*g +: DW] = acc_q[g][DW-1:0];
`endif
  end

  assign gnt       = gnt_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Directed bench for mm_job_arbiter (DW=8, RR_INIT=0): vector table plus backpressure, reset and contention sequences.
module tb_mm_job_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [31:0] a0, b0, a1, b1;
  logic [1:0]  gnt;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic        res_id;
  logic [31:0] res_c;

  int checks;
  int failures;

  mm_job_arbiter #(.DW(8), .RR_INIT(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .gnt       (gnt),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_c     (res_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  req;
    logic [31:0] a0, b0, a1, b1;
    logic [1:0]  gnt;
    logic        id;
    logic [31:0] res_wrap;
    logic [31:0] res_sat;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [31:0] w, input logic [31:0] s);
`ifdef MM_SAT_EN
    return s;
`else
    return w;
`endif
  endfunction

  // Entered at a negedge; request is sampled on the next posedge.
  task automatic run_job(input string nm, input logic [1:0] rq,
                         input logic [31:0] va0, input logic [31:0] vb0,
                         input logic [31:0] va1, input logic [31:0] vb1,
                         input logic [1:0] eg, input logic eid, input logic [31:0] eres,
                         input bit drop, input bit accept);
    int cnt;
    bit extra;
    req = rq; a0 = va0; b0 = vb0; a1 = va1; b1 = vb1;
    @(negedge clk);
    chk({nm, "_gnt"}, 64'(gnt), 64'(eg));
    chk({nm, "_busy_mac"}, 64'(busy), 64'd1);
    if (drop) begin
      req = 2'b00;
      a0 = '1; b0 = '1; a1 = '1; b1 = '1;
    end
    cnt = 0;
    extra = 1'b0;
    while (res_valid !== 1'b1 && cnt < 20) begin
      @(negedge clk);
      cnt++;
      if (gnt !== 2'b00) extra = 1'b1;
    end
    chk({nm, "_latency"}, 64'(cnt), 64'd8);
    chk({nm, "_extra_gnt"}, 64'(extra), 64'd0);
    chk({nm, "_res_id"}, 64'(res_id), 64'(eid));
    chk({nm, "_res_c"}, 64'(res_c), 64'(eres));
    chk({nm, "_busy_done"}, 64'(busy), 64'd1);
    if (accept) begin
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
      chk({nm, "_valid_drop"}, 64'(res_valid), 64'd0);
      chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit ok;
    checks = 0;
    failures = 0;

    // req, a0, b0, a1, b1, gnt, id, wrapped result, saturated result
    vecs[0] = '{2'b01, 32'h04030201, 32'h08070605, 32'h00000000, 32'h00000000, 2'b01, 1'b0, 32'h322B1613, 32'h322B1613};
    vecs[1] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h04030201, 32'h01000001, 2'b10, 1'b1, 32'h04030201, 32'h04030201};
    vecs[2] = '{2'b01, 32'h10101010, 32'h10101010, 32'h00000000, 32'h00000000, 2'b01, 1'b0, 32'h00000000, 32'hFFFFFFFF};
    vecs[3] = '{2'b10, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b10, 1'b1, 32'h02020202, 32'hFFFFFFFF};
    vecs[4] = '{2'b01, 32'h03000002, 32'h281E140A, 32'h00000000, 32'h00000000, 2'b01, 1'b0, 32'h785A2814, 32'h785A2814};
    vecs[5] = '{2'b01, 32'h000001C8, 32'h01010102, 32'h00000000, 32'h00000000, 2'b01, 1'b0, 32'h0000C991, 32'h0000C9FF};

    rst_n = 1'b0; req = 2'b00; res_ready = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {27'd0, gnt, busy, res_valid, res_id, res_c}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_outputs", {27'd0, gnt, busy, res_valid, res_id, res_c}, 64'd0);

    // Table-driven jobs; operands are scrambled right after the grant.
    for (int i = 0; i < 6; i++) begin
      run_job($sformatf("vec%0d", i), vecs[i].req, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1,
              vecs[i].gnt, vecs[i].id, pick(vecs[i].res_wrap, vecs[i].res_sat), 1'b1, 1'b1);
    end

    // Backpressure: DONE held 20 cycles while requester 1 waits.
    run_job("bp0", 2'b01, 32'h04030201, 32'h08070605, 32'h0, 32'h0, 2'b01, 1'b0, 32'h322B1613, 1'b1, 1'b0);
    req = 2'b10; a1 = 32'h04030201; b1 = 32'h01000001;
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_c !== 32'h322B1613 || res_id !== 1'b0 || gnt !== 2'b00) ok = 1'b0;
    end
    chk("bp_hold_stable", 64'(ok), 64'd1);
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("bp_idle_cycle", {59'd0, gnt, busy, res_valid}, 64'd0);
    run_job("bp1", 2'b10, 32'h0, 32'h0, 32'h04030201, 32'h01000001, 2'b10, 1'b1, 32'h04030201, 1'b1, 1'b1);

    // Reset asserted at MAC step 4 aborts the job.
    req = 2'b10; a1 = 32'h04030201; b1 = 32'h08070605;
    @(negedge clk);
    chk("rst_job_gnt", 64'(gnt), 64'(2'b10));
    req = 2'b00;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mac_outputs", {27'd0, gnt, busy, res_valid, res_id, res_c}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || gnt !== 2'b00 || busy !== 1'b0) ok = 1'b0;
    end
    chk("rst_no_result", 64'(ok), 64'd1);

    // Contention: req=11 held, priority restarts at requester 0 after reset.
    for (int j = 0; j < 4; j++) begin
      run_job($sformatf("rr%0d", j), 2'b11, 32'h04030201, 32'h08070605, 32'h04030201, 32'h01000001,
              (j % 2 == 0) ? 2'b01 : 2'b10, 1'(j % 2),
              (j % 2 == 0) ? 32'h322B1613 : 32'h04030201, 1'b0, 1'b1);
    end
    req = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
